baud_cfg_ctrl: RTL
==================

Name: baud_cfg_ctrl

Overview:
Runtime configuration controller for the fractional-N baud tick generator. It accepts a requested baud rate over a valid/ready handshake and derives the generator's divisor triple (N, R, FTICK) with a sequential multiplier/divider. It validates the result and hands the new triple to the generator only at a tick boundary, so no tick period is ever split between two configurations. It sits between the host/CSR side and the tick generator, and is the only writer of the generator's divisor inputs.

Parameters:
F_CLK, 50_000_000, input clock frequency in Hz (must fit 32 bits)
OSR, 16, oversampling ratio (ticks per bit), >=1
DEF_BAUD, 115200, baud rate in effect out of reset
BAUD_W, 24, width of the requested baud field
N_W, 16, width of the integer divisor output; larger N0 is rejected
SYNC_BIT, 0, 0 = apply on tick_osr boundary, 1 = apply on tick_bit boundary

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  request strobe
cfg_ready  out  1  controller can accept a request
cfg_baud  in  BAUD_W  requested baud rate, sampled on acceptance
cfg_done  out  1  1-cycle pulse: request finished (applied or rejected)
cfg_err  out  1  last request rejected; held until next acceptance
tick_osr  in  1  oversample tick from generator
tick_bit  in  1  bit tick from generator
gen_n  out  N_W  integer divisor N0 = floor(F_CLK/FTICK)
gen_r  out  32  remainder R = F_CLK - N0*FTICK
gen_ftick  out  32  FTICK = baud*OSR
gen_load  out  1  1-cycle pulse: generator reloads counter/accumulator from gen_*
active_baud  out  BAUD_W  baud currently applied

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; cfg_ready=1 after reset deasserts; cfg_done=0, cfg_err=0, gen_load=0. gen_n/gen_r/gen_ftick/active_baud take the values derived from DEF_BAUD at elaboration (constant arithmetic, not the divider).
- FSM states: IDLE, MUL, DIV, CHECK, WAIT_TICK, APPLY.
- IDLE: cfg_ready=1 only here. cfg_valid&&cfg_ready at edge -> latch cfg_baud, clear cfg_err, go to MUL. cfg_valid outside IDLE is ignored (not queued).
- MUL (1 cycle): compute the 40-bit product baud*OSR. Flag an error if baud==0 or the product is >=2^32. Go to DIV.
- DIV (exactly 32 cycles): restoring division, 1 quotient bit per cycle MSB-first, of F_CLK by FTICK. Use a 33-bit partial remainder. If the MUL error flag is set, skip the division result but still take 32 cycles (fixed latency).
- CHECK (1 cycle): reject if any of: MUL error, quotient==0 (FTICK>F_CLK), quotient>2^N_W-1.
  - Reject -> cfg_err=1, cfg_done pulse, gen_* unchanged, go to IDLE.
  - Otherwise -> go to WAIT_TICK.
- WAIT_TICK: wait for tick_osr (SYNC_BIT=0) or tick_bit (SYNC_BIT=1) sampled high. If the tick is already high in the first WAIT_TICK cycle, it counts. Go to APPLY.
- APPLY (1 cycle): update gen_n, gen_r, gen_ftick and active_baud on this edge; gen_load=1, cfg_done=1; go to IDLE.
- gen_* outputs change only in APPLY or reset and are stable otherwise.
- Fixed latency, acceptance to CHECK decision: 1+1+32 = 34 cycles; cfg_done for a reject is asserted in cycle 35. Apply latency is 35 cycles plus the wait for the tick.
- Reset mid-operation (any state): abort, discard the pending request, restore DEF_BAUD values, no gen_load pulse.
- R==0 is a valid configuration (exact division); gen_r=0.

Test Plan:
- Reset, idle 5 cycles -> gen_n=27, gen_r=233600, gen_ftick=1843200, active_baud=115200, gen_load never pulses, cfg_ready=1.
- Request 9600, tick_osr every 27 cycles -> cfg_ready low 1 cycle after accept; gen_load coincides with cfg_done 1 cycle after the first tick_osr seen in WAIT_TICK, no earlier than 35 cycles after accept; gen_n=325, gen_r=80000, gen_ftick=153600, cfg_err=0.
- Request 3_125_000 -> gen_n=1, gen_r=0, gen_ftick=50_000_000 applied; cfg_err=0.
- Request 4_000_000, 0, and 40 (N0=78125>65535) in turn -> each gives cfg_err=1 with cfg_done in cycle 35 after accept; gen_* and active_baud stay at the previous values; no gen_load.
- SYNC_BIT=1, request 9600, with tick_osr pulsing but tick_bit delayed 200 cycles -> apply waits for tick_bit; gen_* stable until APPLY.
- Assert rst during DIV (cycle 10 after accept), then during WAIT_TICK -> outputs return to DEF_BAUD values; no gen_load or cfg_done; the next request completes normally.

Source files
------------

// File: rtl/baud_cfg_ctrl.sv
// Runtime divisor controller for the fractional-N baud tick generator.
// Derives (N, R, FTICK) from a requested baud and applies it only on a tick boundary.
module baud_cfg_ctrl #(
  parameter int unsigned F_CLK    = 50_000_000,
  parameter int unsigned OSR      = 16,
  parameter int unsigned DEF_BAUD = 115200,
  parameter int unsigned BAUD_W   = 24,
  parameter int unsigned N_W      = 16,
  parameter int unsigned SYNC_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [BAUD_W-1:0] cfg_baud,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic              tick_osr,
  input  logic              tick_bit,
  output logic [N_W-1:0]    gen_n,
  output logic [31:0]       gen_r,
  output logic [31:0]       gen_ftick,
  output logic              gen_load,
  output logic [BAUD_W-1:0] active_baud
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, CHECK, WAIT_TICK, APPLY} state_e;

  localparam logic [63:0] DEF_FT = 64'(DEF_BAUD) * 64'(OSR);
  localparam logic [63:0] DEF_N  = 64'(F_CLK) / DEF_FT;
  localparam logic [63:0] DEF_R  = 64'(F_CLK) - DEF_N * DEF_FT;
  localparam logic [31:0] FCLK   = 32'(F_CLK);
  localparam logic [32:0] N_MAX  = (33'd1 << N_W) - 33'd1;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [31:0]         ftick_q, ftick_d;
  logic                merr_q, merr_d;
  logic [31:0]         quo_q, quo_d;
  logic [31:0]         rem_q, rem_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [N_W-1:0]      gen_n_q, gen_n_d;
  logic [31:0]         gen_r_q, gen_r_d;
  logic [31:0]         gen_ftick_q, gen_ftick_d;
  logic [BAUD_W-1:0]   active_q, active_d;
  logic                cfg_err_q, cfg_err_d;
  logic                done_q, done_d;
  logic                load_q, load_d;

  logic [39:0]         prod;
  logic [32:0]         rem_sh;
  logic                tick_sel;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    ftick_d     = ftick_q;
    merr_d      = merr_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    gen_n_d     = gen_n_q;
    gen_r_d     = gen_r_q;
    gen_ftick_d = gen_ftick_q;
    active_d    = active_q;
    cfg_err_d   = cfg_err_q;
    done_d      = 1'b0;
    load_d      = 1'b0;
    prod        = 40'(baud_q) * 40'(OSR);
    // restoring division step: bring down the next dividend bit, MSB first
    rem_sh      = {rem_q, FCLK[cnt_q]};
    tick_sel    = (SYNC_BIT != 0) ? tick_bit : tick_osr;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          baud_d    = cfg_baud;
          cfg_err_d = 1'b0;
          state_d   = MUL;
        end
      end
      MUL: begin
        ftick_d = prod[31:0];
        merr_d  = (baud_q == '0) || (prod[39:32] != 8'd0);
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = 5'd31;
        state_d = DIV;
      end
      DIV: begin
        // runs the full 32 steps even on a MUL error to keep latency fixed
        if (rem_sh >= {1'b0, ftick_q}) begin
          rem_d = 32'(rem_sh - {1'b0, ftick_q});
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 5'd1;
      end
      CHECK: begin
        if (merr_q || (quo_q == '0) || ({1'b0, quo_q} > N_MAX)) begin
          cfg_err_d = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d   = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        // new triple is visible in the same cycle gen_load pulses
        if (tick_sel) begin
          gen_n_d     = quo_q[N_W-1:0];
          gen_r_d     = rem_q;
          gen_ftick_d = ftick_q;
          active_d    = baud_q;
          load_d      = 1'b1;
          done_d      = 1'b1;
          state_d     = APPLY;
        end
      end
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      ftick_q     <= '0;
      merr_q      <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      gen_n_q     <= N_W'(DEF_N);
      gen_r_q     <= 32'(DEF_R);
      gen_ftick_q <= 32'(DEF_FT);
      active_q    <= BAUD_W'(DEF_BAUD);
      cfg_err_q   <= 1'b0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      ftick_q     <= ftick_d;
      merr_q      <= merr_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      gen_n_q     <= gen_n_d;
      gen_r_q     <= gen_r_d;
      gen_ftick_q <= gen_ftick_d;
      active_q    <= active_d;
      cfg_err_q   <= cfg_err_d;
      done_q      <= done_d;
      load_q      <= load_d;
    end
  end

  assign cfg_ready   = (state_q == IDLE);
  assign cfg_done    = done_q;
  assign cfg_err     = cfg_err_q;
  assign gen_load    = load_q;
  assign gen_n       = gen_n_q;
  assign gen_r       = gen_r_q;
  assign gen_ftick   = gen_ftick_q;
  assign active_baud = active_q;

endmodule
